// File: rtl/nios_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the CPU debug slave and the JTAG path.
// Round-robin grant, auto-incrementing JTAG address, one-deep JTAG command slot.
module nios_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_RD,
        JTAG_ACC,
        JTAG_RD
    } state_t;

    state_t state, state_n;

    logic              cpu_req;
    logic              cpu_wr;
    logic              lg_jtag;
    logic              pending;
    logic              pend_wr;
    logic [31:0]       pend_data;
    logic [ADDR_W-1:0] jaddr;
    logic              wren_q;
    logic              grant_cpu, grant_jtag;
    logic              jtag_done, jtag_rd_done;
    logic [1:0]        n_strobes;
    logic              any_strobe, accept, drop;
    logic              acc_a, acc_b, acc_n;

    assign cpu_req = avs_read | avs_write;

    assign n_strobes  = {1'b0, take_action_ocimem_a} + {1'b0, take_action_ocimem_b}
                      + {1'b0, take_no_action_ocimem_a};
    assign any_strobe = |n_strobes;
    assign accept     = any_strobe & ~pending;
    assign drop       = (any_strobe & pending) | (n_strobes > 2'd1);
    assign acc_a      = accept & take_action_ocimem_a;
    assign acc_b      = accept & ~take_action_ocimem_a & take_action_ocimem_b;
    assign acc_n      = accept & ~take_action_ocimem_a & ~take_action_ocimem_b;

    // Reset kills a write already on the RAM port so it never lands.
    assign ram_wren = wren_q & ~reset;

    assign avs_readdata    = ram_rdata;
    assign avs_waitrequest = cpu_req
                           & ~(((state == CPU_ACC) && cpu_wr) || (state == CPU_RD));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n      = state;
        grant_cpu    = 1'b0;
        grant_jtag   = 1'b0;
        jtag_done    = 1'b0;
        jtag_rd_done = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && pending) begin
                    grant_cpu  = lg_jtag;
                    grant_jtag = ~lg_jtag;
                end else begin
                    grant_cpu  = cpu_req;
                    grant_jtag = pending;
                end
                if (grant_cpu)  state_n = CPU_ACC;
                if (grant_jtag) state_n = JTAG_ACC;
            end
            CPU_ACC:  state_n = cpu_wr ? IDLE : CPU_RD;
            CPU_RD:   state_n = IDLE;
            JTAG_ACC: begin
                jtag_done = pend_wr;
                state_n   = pend_wr ? IDLE : JTAG_RD;
            end
            JTAG_RD: begin
                jtag_done    = 1'b1;
                jtag_rd_done = 1'b1;
                state_n      = IDLE;
            end
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr      <= '0;
            ram_wdata     <= '0;
            wren_q        <= 1'b0;
            cpu_wr        <= 1'b0;
            lg_jtag       <= 1'b1;
            pending       <= 1'b0;
            pend_wr       <= 1'b0;
            pend_data     <= '0;
            jaddr         <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            if (grant_cpu) begin
                ram_addr  <= avs_address;
                ram_wdata <= avs_writedata;
                wren_q    <= avs_write & ~avs_read;
                cpu_wr    <= avs_write & ~avs_read;
                lg_jtag   <= 1'b0;
            end
            if (grant_jtag) begin
                ram_addr  <= jaddr;
                ram_wdata <= pend_data;
                wren_q    <= pend_wr;
                lg_jtag   <= 1'b1;
            end
            if (jtag_done) begin
                pending       <= 1'b0;
                jaddr         <= jaddr + ADDR_W'(1);
                monitor_ready <= 1'b1;
            end
            if (jtag_rd_done) MonDReg <= ram_rdata;
            // Intake only happens with pending clear, so it never collides with jtag_done.
            if (acc_a) begin
                jaddr         <= jdo[ADDR_W+1:2];
                pending       <= jdo[37];
                pend_wr       <= 1'b0;
                monitor_ready <= ~jdo[37];
            end
            if (acc_b) begin
                pending       <= 1'b1;
                pend_wr       <= 1'b1;
                pend_data     <= jdo[34:3];
                monitor_ready <= 1'b0;
            end
            if (acc_n) begin
                pending       <= 1'b1;
                pend_wr       <= 1'b0;
                monitor_ready <= 1'b0;
            end
            if (acc_a)     monitor_error <= 1'b0;
            else if (drop) monitor_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nios_ocimem_arbiter.sv
// Directed bench for nios_ocimem_arbiter with a 1-cycle-latency RAM model.
module tb_nios_ocimem_arbiter;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read, avs_write;
    logic [31:0]       avs_writedata, avs_readdata;
    logic              avs_waitrequest;
    logic              take_a, take_b, take_n;
    logic [37:0]       jdo;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [31:0]       ram_wdata, ram_rdata;
    logic [31:0]       MonDReg;
    logic              monitor_ready, monitor_error;

    logic [31:0] mem [0:255];
    int wr_cnt = 0;
    int chk = 0;
    int pass = 0;
    int w0;

    nios_ocimem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .avs_address            (avs_address),
        .avs_read               (avs_read),
        .avs_write              (avs_write),
        .avs_writedata          (avs_writedata),
        .avs_readdata           (avs_readdata),
        .avs_waitrequest        (avs_waitrequest),
        .take_action_ocimem_a   (take_a),
        .take_action_ocimem_b   (take_b),
        .take_no_action_ocimem_a(take_n),
        .jdo                    (jdo),
        .ram_addr               (ram_addr),
        .ram_wren               (ram_wren),
        .ram_wdata              (ram_wdata),
        .ram_rdata              (ram_rdata),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_strobes();
        take_a = 1'b0;
        take_b = 1'b0;
        take_n = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk++; if (ram_wren !== 1'b0) $display("FAIL rst_wren got %h want 0", ram_wren); else pass++;
        chk++; if (ram_addr !== 8'h00) $display("FAIL rst_addr got %h want 00", ram_addr); else pass++;
        chk++; if (ram_wdata !== 32'h0) $display("FAIL rst_wdata got %h want 0", ram_wdata); else pass++;
        chk++; if (MonDReg !== 32'h0) $display("FAIL rst_mondreg got %h want 0", MonDReg); else pass++;
        chk++; if (monitor_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", monitor_ready); else pass++;
        chk++; if (monitor_error !== 1'b0) $display("FAIL rst_error got %b want 0", monitor_error); else pass++;
        chk++; if (avs_waitrequest !== 1'b0) $display("FAIL rst_wait got %b want 0", avs_waitrequest); else pass++;
        step();
    endtask

    task automatic test_cpu_write();
        avs_address   = 8'h10;
        avs_writedata = 32'hDEADBEEF;
        avs_write     = 1'b1;
        #1;
        chk++; if (avs_waitrequest !== 1'b1) $display("FAIL cw_wait0 got %b want 1", avs_waitrequest); else pass++;
        step();
        chk++; if (avs_waitrequest !== 1'b0) $display("FAIL cw_wait1 got %b want 0", avs_waitrequest); else pass++;
        chk++; if (ram_wren !== 1'b1) $display("FAIL cw_wren got %b want 1", ram_wren); else pass++;
        chk++; if (ram_addr !== 8'h10) $display("FAIL cw_addr got %h want 10", ram_addr); else pass++;
        step();
        avs_write = 1'b0;
        chk++; if (ram_wren !== 1'b0) $display("FAIL cw_wren_off got %b want 0", ram_wren); else pass++;
        chk++; if (mem[8'h10] !== 32'hDEADBEEF) $display("FAIL cw_mem got %h want deadbeef", mem[8'h10]); else pass++;
    endtask

    task automatic test_cpu_read();
        step();
        avs_address = 8'h10;
        avs_read    = 1'b1;
        #1;
        chk++; if (avs_waitrequest !== 1'b1) $display("FAIL cr_wait0 got %b want 1", avs_waitrequest); else pass++;
        step();
        chk++; if (avs_waitrequest !== 1'b1) $display("FAIL cr_wait1 got %b want 1", avs_waitrequest); else pass++;
        step();
        chk++; if (avs_waitrequest !== 1'b0) $display("FAIL cr_wait2 got %b want 0", avs_waitrequest); else pass++;
        chk++; if (avs_readdata !== 32'hDEADBEEF) $display("FAIL cr_data got %h want deadbeef", avs_readdata); else pass++;
        avs_read = 1'b0;
        step();
    endtask

    task automatic test_jtag_write();
        jdo = '0;
        jdo[9:2] = 8'hFF;
        take_a = 1'b1;
        step();
        clr_strobes();
        chk++; if (monitor_ready !== 1'b1) $display("FAIL ja_ready got %b want 1", monitor_ready); else pass++;
        for (int k = 0; k < 2; k++) begin
            jdo = '0;
            jdo[34:3] = 32'h1234;
            take_b = 1'b1;
            step();
            clr_strobes();
            chk++; if (monitor_ready !== 1'b0) $display("FAIL jb_busy%0d got %b want 0", k, monitor_ready); else pass++;
            step();
            chk++; if (ram_wren !== 1'b1) $display("FAIL jb_wren%0d got %b want 1", k, ram_wren); else pass++;
            chk++; if (ram_addr !== (k == 0 ? 8'hFF : 8'h00)) $display("FAIL jb_addr%0d got %h", k, ram_addr); else pass++;
            step();
            chk++; if (monitor_ready !== 1'b1) $display("FAIL jb_ready%0d got %b want 1", k, monitor_ready); else pass++;
        end
        chk++; if (mem[8'hFF] !== 32'h1234) $display("FAIL jb_memff got %h want 1234", mem[8'hFF]); else pass++;
        chk++; if (mem[8'h00] !== 32'h1234) $display("FAIL jb_mem00 got %h want 1234", mem[8'h00]); else pass++;
    endtask

    task automatic test_jtag_read();
        step();
        jdo = '0;
        jdo[9:2] = 8'h10;
        jdo[37]  = 1'b1;
        take_a = 1'b1;
        step();
        clr_strobes();
        chk++; if (monitor_ready !== 1'b0) $display("FAIL jr_ready1 got %b want 0", monitor_ready); else pass++;
        step(2);
        chk++; if (monitor_ready !== 1'b0) $display("FAIL jr_ready2 got %b want 0", monitor_ready); else pass++;
        step();
        chk++; if (monitor_ready !== 1'b1) $display("FAIL jr_ready3 got %b want 1", monitor_ready); else pass++;
        chk++; if (MonDReg !== 32'hDEADBEEF) $display("FAIL jr_data got %h want deadbeef", MonDReg); else pass++;
    endtask

    task automatic test_arbitration();
        jdo = '0;
        take_a = 1'b1;
        step();
        clr_strobes();
        avs_address = 8'h10;
        avs_read    = 1'b1;
        take_n      = 1'b1;
        step();
        clr_strobes();
        chk++; if (ram_addr !== 8'h10) $display("FAIL arb_cpu_first got %h want 10", ram_addr); else pass++;
        step();
        chk++; if (avs_readdata !== 32'hDEADBEEF || avs_waitrequest !== 1'b0)
            $display("FAIL arb_cpu_data got %h/%b want deadbeef/0", avs_readdata, avs_waitrequest); else pass++;
        avs_read = 1'b0;
        step(2);
        chk++; if (ram_addr !== 8'h00) $display("FAIL arb_jtag_next got %h want 00", ram_addr); else pass++;
        step(2);
        chk++; if (MonDReg !== 32'h1234 || monitor_ready !== 1'b1)
            $display("FAIL arb_jtag_data got %h/%b want 1234/1", MonDReg, monitor_ready); else pass++;
        avs_address   = 8'h30;
        avs_writedata = 32'hCAFEF00D;
        avs_write     = 1'b1;
        step();
        take_n = 1'b1;
        step();
        clr_strobes();
        avs_write = 1'b0;
        avs_read  = 1'b1;
        step();
        chk++; if (ram_addr !== 8'h01) $display("FAIL arb_tie_jtag got %h want 01", ram_addr); else pass++;
        chk++; if (avs_waitrequest !== 1'b1) $display("FAIL arb_tie_wait got %b want 1", avs_waitrequest); else pass++;
        step(2);
        chk++; if (monitor_ready !== 1'b1 || MonDReg !== 32'h0)
            $display("FAIL arb_tie_jdata got %h/%b want 0/1", MonDReg, monitor_ready); else pass++;
        step(2);
        chk++; if (avs_readdata !== 32'hCAFEF00D || avs_waitrequest !== 1'b0)
            $display("FAIL arb_tie_cpu got %h/%b want cafef00d/0", avs_readdata, avs_waitrequest); else pass++;
        avs_read = 1'b0;
        step();
    endtask

    task automatic test_error();
        w0 = wr_cnt;
        jdo = '0;
        jdo[34:3] = 32'h5555;
        take_b = 1'b1;
        step();
        clr_strobes();
        take_n = 1'b1;
        step();
        clr_strobes();
        chk++; if (monitor_error !== 1'b1) $display("FAIL err_set got %b want 1", monitor_error); else pass++;
        step(4);
        chk++; if (mem[8'h02] !== 32'h5555) $display("FAIL err_mem got %h want 5555", mem[8'h02]); else pass++;
        chk++; if (wr_cnt - w0 !== 1) $display("FAIL err_wrcnt got %0d want 1", wr_cnt - w0); else pass++;
        chk++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b1)
            $display("FAIL err_hold got %b/%b want 1/1", monitor_ready, monitor_error); else pass++;
        jdo = '0;
        jdo[9:2] = 8'h10;
        take_a = 1'b1;
        step();
        clr_strobes();
        chk++; if (monitor_error !== 1'b0) $display("FAIL err_clear got %b want 0", monitor_error); else pass++;
        jdo = '0;
        jdo[34:3] = 32'h77;
        take_b = 1'b1;
        take_n = 1'b1;
        step();
        clr_strobes();
        chk++; if (monitor_error !== 1'b1) $display("FAIL err_multi got %b want 1", monitor_error); else pass++;
        step(2);
        chk++; if (mem[8'h10] !== 32'h77 || monitor_ready !== 1'b1)
            $display("FAIL err_multi_wr got %h/%b want 77/1", mem[8'h10], monitor_ready); else pass++;
    endtask

    task automatic test_reset_mid();
        step();
        w0 = wr_cnt;
        avs_address   = 8'h40;
        avs_writedata = 32'hBAD;
        avs_write     = 1'b1;
        step();
        chk++; if (ram_wren !== 1'b1) $display("FAIL rm_wren_on got %b want 1", ram_wren); else pass++;
        reset     = 1'b1;
        avs_write = 1'b0;
        #1;
        chk++; if (ram_wren !== 1'b0) $display("FAIL rm_wren_kill got %b want 0", ram_wren); else pass++;
        step();
        chk++; if (mem[8'h40] !== 32'h0 || wr_cnt !== w0)
            $display("FAIL rm_mem got %h/%0d want 0/%0d", mem[8'h40], wr_cnt, w0); else pass++;
        chk++; if (ram_addr !== 8'h0 || ram_wdata !== 32'h0 || MonDReg !== 32'h0)
            $display("FAIL rm_regs got %h/%h/%h want 0", ram_addr, ram_wdata, MonDReg); else pass++;
        chk++; if (monitor_ready !== 1'b0 || monitor_error !== 1'b0)
            $display("FAIL rm_flags got %b/%b want 0/0", monitor_ready, monitor_error); else pass++;
        reset = 1'b0;
        step();
        take_n = 1'b1;
        step();
        clr_strobes();
        step(3);
        chk++; if (MonDReg !== 32'h1234 || monitor_ready !== 1'b1)
            $display("FAIL rm_jaddr0 got %h/%b want 1234/1", MonDReg, monitor_ready); else pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        jdo = '0;
        clr_strobes();
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_jtag_write();
        test_jtag_read();
        test_arbitration();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
